// File: rtl/arbitro_banco_de_registros_pkg.sv
// Shared definitions for the register-bank arbiter.
//   state_t : arbiter FSM encoding (ARB, LOCK_A, LOCK_B)
//   ID_A/ID_B : requester ids, also used as the round-robin priority value
package arbitro_banco_de_registros_pkg;

  typedef enum logic [1:0] {
    ARB    = 2'd0,
    LOCK_A = 2'd1,
    LOCK_B = 2'd2
  } state_t;

  localparam logic ID_A = 1'b0;
  localparam logic ID_B = 1'b1;

endpackage

// File: rtl/arbitro_rr2.sv
// Two-way round-robin grant.
//   req_a/req_b : requests
//   prio        : requester that wins a tie (ID_A / ID_B)
//   gnt_a/gnt_b : one-hot (or zero) grant
//   prio_nxt    : priority after this grant (the requester that did not win)
module arbitro_rr2
  import arbitro_banco_de_registros_pkg::*;
(
  input  logic req_a,
  input  logic req_b,
  input  logic prio,
  output logic gnt_a,
  output logic gnt_b,
  output logic prio_nxt
);

  always_comb begin
    gnt_a    = req_a & (~req_b | (prio == ID_A));
    gnt_b    = req_b & ~gnt_a;
    prio_nxt = prio;
    if (gnt_a)      prio_nxt = ID_B;
    else if (gnt_b) prio_nxt = ID_A;
  end

endmodule

// File: rtl/arbitro_banco_de_registros.sv
// Two-requester arbiter in front of a 2R/1W register bank.
//   Client side (A and B): req/lock/we, rs1/rs2/rd addresses, din in;
//     gnt (combinational), vld (1-cycle pulse after gnt), dout1/dout2 out.
//   Bank side: addr_rs1/addr_rs2/addr_rd/we/data_in out, rs1/rs2 read data in.
// Round-robin between A and B; a granted client may hold the bank with lock_x
// for at most LOCK_MAX consecutive grants, then is forced out and its lock
// request is ignored until it has been deasserted for one cycle.
module arbitro_banco_de_registros
  import arbitro_banco_de_registros_pkg::*;
#(
  parameter int N        = 5,
  parameter int M        = 32,
  parameter int LOCK_MAX = 8,
  parameter int ZERO_REG = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_a,
  input  logic         lock_a,
  input  logic         we_a,
  input  logic [N-1:0] rs1_a,
  input  logic [N-1:0] rs2_a,
  input  logic [N-1:0] rd_a,
  input  logic [M-1:0] din_a,
  output logic         gnt_a,
  output logic         vld_a,
  output logic [M-1:0] dout1_a,
  output logic [M-1:0] dout2_a,
  input  logic         req_b,
  input  logic         lock_b,
  input  logic         we_b,
  input  logic [N-1:0] rs1_b,
  input  logic [N-1:0] rs2_b,
  input  logic [N-1:0] rd_b,
  input  logic [M-1:0] din_b,
  output logic         gnt_b,
  output logic         vld_b,
  output logic [M-1:0] dout1_b,
  output logic [M-1:0] dout2_b,
  output logic [N-1:0] addr_rs1,
  output logic [N-1:0] addr_rs2,
  output logic [N-1:0] addr_rd,
  output logic         we,
  output logic [M-1:0] data_in,
  input  logic [M-1:0] rs1,
  input  logic [M-1:0] rs2
);

  localparam int            CW      = $clog2(LOCK_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(LOCK_MAX);

  state_t        state_q, state_d;
  logic          prio_q, prio_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          ign_a_q, ign_a_d, ign_b_q, ign_b_d;
  logic          rr_gnt_a, rr_gnt_b, rr_prio;
  logic          g_a, g_b, use_rr;
  logic          ok_a, ok_b;

  arbitro_rr2 u_rr (
    .req_a    (req_a),
    .req_b    (req_b),
    .prio     (prio_q),
    .gnt_a    (rr_gnt_a),
    .gnt_b    (rr_gnt_b),
    .prio_nxt (rr_prio)
  );

  assign cnt_inc = cnt_q + CW'(1);

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    cnt_d   = cnt_q;
    // ignore flag clears once lock has been seen low at a clock edge
    ign_a_d = ign_a_q & lock_a;
    ign_b_d = ign_b_q & lock_b;
    g_a     = 1'b0;
    g_b     = 1'b0;
    use_rr  = 1'b0;
    unique case (state_q)
      LOCK_A: begin
        if (req_a) begin
          g_a   = 1'b1;
          cnt_d = cnt_inc;
          if (!lock_a || cnt_inc >= CNT_MAX) begin
            state_d = ARB;
            prio_d  = ID_B;
            cnt_d   = '0;
            if (lock_a) ign_a_d = 1'b1;  // forced release
          end
        end else begin
          use_rr = 1'b1;
        end
      end
      LOCK_B: begin
        if (req_b) begin
          g_b   = 1'b1;
          cnt_d = cnt_inc;
          if (!lock_b || cnt_inc >= CNT_MAX) begin
            state_d = ARB;
            prio_d  = ID_A;
            cnt_d   = '0;
            if (lock_b) ign_b_d = 1'b1;
          end
        end else begin
          use_rr = 1'b1;
        end
      end
      default: use_rr = 1'b1;
    endcase
    // plain round-robin cycle; a lock request (not being ignored) opens a lock
    if (use_rr) begin
      g_a     = rr_gnt_a;
      g_b     = rr_gnt_b;
      prio_d  = rr_prio;
      state_d = ARB;
      cnt_d   = '0;
      if (g_a && lock_a && !ign_a_q) begin
        state_d = LOCK_A;
        cnt_d   = CW'(1);
      end else if (g_b && lock_b && !ign_b_q) begin
        state_d = LOCK_B;
        cnt_d   = CW'(1);
      end
    end
  end

  // grants are forced low for the whole time reset is asserted
  assign gnt_a = g_a & rst;
  assign gnt_b = g_b & rst;

  assign ok_a = (ZERO_REG == 0) || (rd_a != '0);
  assign ok_b = (ZERO_REG == 0) || (rd_b != '0);

  always_comb begin
    addr_rs1 = '0;
    addr_rs2 = '0;
    addr_rd  = '0;
    data_in  = '0;
    we       = 1'b0;
    if (gnt_a) begin
      addr_rs1 = rs1_a;
      addr_rs2 = rs2_a;
      addr_rd  = rd_a;
      data_in  = din_a;
      we       = we_a & ok_a;
    end else if (gnt_b) begin
      addr_rs1 = rs1_b;
      addr_rs2 = rs2_b;
      addr_rd  = rd_b;
      data_in  = din_b;
      we       = we_b & ok_b;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ARB;
      prio_q  <= ID_A;
      cnt_q   <= '0;
      ign_a_q <= 1'b0;
      ign_b_q <= 1'b0;
      vld_a   <= 1'b0;
      vld_b   <= 1'b0;
      dout1_a <= '0;
      dout2_a <= '0;
      dout1_b <= '0;
      dout2_b <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      cnt_q   <= cnt_d;
      ign_a_q <= ign_a_d;
      ign_b_q <= ign_b_d;
      vld_a   <= gnt_a;
      vld_b   <= gnt_b;
      // read data sampled at the same edge that commits the write: old value
      if (gnt_a) begin
        dout1_a <= rs1;
        dout2_a <= rs2;
      end
      if (gnt_b) begin
        dout1_b <= rs1;
        dout2_b <= rs2;
      end
    end
  end

endmodule
